// File: rtl/light_sequencer_if.sv
// Control/status bundle between the room-light sequencer and its environment.
// The master side drives the requests; the slave side (the sequencer) drives level/state/PWM.
interface light_sequencer_if;
    logic       app_switch;
    logic       movement;
    logic       dark;
    logic [7:0] room_intensity;
    logic [7:0] level;
    logic [1:0] state;
    logic       light_control;

    modport master (
        output app_switch, movement, dark, room_intensity,
        input  level, state, light_control
    );

    modport slave (
        input  app_switch, movement, dark, room_intensity,
        output level, state, light_control
    );
endinterface

// File: rtl/light_sequencer.sv
// Room-light sequencer: manual/auto arbitration, occupancy hold, brightness ramp and PWM drive.
// Define LIGHT_SEQ_INSTANT_EN to bypass ramping (level jumps to target, no prescaler).
module light_sequencer #(
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned RAMP_DIV    = 4
) (
    input  logic           clk,
    input  logic           rst,
    light_sequencer_if.slave bus
);

    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RAMP = 2'd1,
        S_ON   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_level;
    logic [7:0]      w_level_next;
    logic [HW-1:0]   r_hold_cnt;
    logic [HW-1:0]   w_hold_next;
    logic [7:0]      r_pwm_cnt;
    logic            r_light;
    logic            w_request;
    logic [7:0]      w_target;
    logic            w_step;

    assign w_request = bus.app_switch | (bus.dark & bus.movement);
    assign w_target  = (w_request || (r_state == S_HOLD)) ? bus.room_intensity : 8'd0;

`ifdef LIGHT_SEQ_INSTANT_EN
    assign w_step = 1'b1;
`else
    localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PW-1:0] r_presc;

    assign w_step = (r_presc == PW'(RAMP_DIV - 1));

    // Held at zero outside RAMP, so every RAMP entry starts a fresh prescale period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (r_state != S_RAMP || w_step) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = '0;
        w_level_next = r_level;

        case (r_state)
            S_OFF: begin
                if (w_request) begin
                    w_state_next = S_RAMP;
                end
            end

            S_RAMP: begin
                if (r_level == w_target) begin
                    w_state_next = (w_target != 8'd0) ? S_ON : S_OFF;
                end else if (w_step) begin
`ifdef LIGHT_SEQ_INSTANT_EN
                    w_level_next = w_target;
`else
                    w_level_next = (w_target > r_level) ? r_level + 8'd1 : r_level - 8'd1;
`endif
                end
            end

            S_ON: begin
                // Hold entry must win over the target-mismatch path, since target drops to 0 here.
                if (!bus.app_switch && bus.dark && !bus.movement) begin
                    w_state_next = S_HOLD;
                end else if (w_target != r_level) begin
                    w_state_next = S_RAMP;
                end
            end

            S_HOLD: begin
                w_hold_next = r_hold_cnt + HW'(1);
                if (w_request) begin
                    w_hold_next  = '0;
                    w_state_next = (w_target != r_level) ? S_RAMP : S_ON;
                end else if (!bus.dark) begin
                    w_hold_next  = '0;
                    w_state_next = S_RAMP;
                end else if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    w_hold_next  = '0;
                    w_state_next = S_RAMP;
                end
            end

            default: begin
                w_state_next = S_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_OFF;
            r_level    <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_level    <= w_level_next;
            r_hold_cnt <= w_hold_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_light   <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_light   <= (r_level == 8'hFF) | (r_pwm_cnt < r_level);
        end
    end

    assign bus.level         = r_level;
    assign bus.state         = r_state;
    assign bus.light_control = r_light;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed + randomized bench for light_sequencer against a timestamp-based behavioural model.
module tb_light_sequencer;

    localparam int unsigned RAMP_DIV    = 2;
    localparam int unsigned HOLD_CYCLES = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    light_sequencer_if bus ();

    light_sequencer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .RAMP_DIV    (RAMP_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: state as 0..3, level, age = cycles spent in current RAMP/HOLD visit, t = cycles since reset.
    int m_state = 0;
    int m_level = 0;
    int m_age   = 0;
    int m_t     = 0;
    int m_lc    = 0;
    int hi_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int req;
        int tgt;
        if (rst) begin
            m_state = 0; m_level = 0; m_age = 0; m_t = 0; m_lc = 0;
            return;
        end
        req  = bus.app_switch | (bus.dark & bus.movement);
        tgt  = (req != 0 || m_state == 3) ? int'(bus.room_intensity) : 0;
        m_lc = (m_level == 255 || (m_t % 256) < m_level) ? 1 : 0;
        m_t++;
        case (m_state)
            0: if (req != 0) begin m_state = 1; m_age = 0; end
            1: begin
                if (m_level == tgt) m_state = (tgt != 0) ? 2 : 0;
                else begin
                    m_age++;
                    if (m_age % RAMP_DIV == 0) m_level += (tgt > m_level) ? 1 : -1;
                end
            end
            2: begin
                if (!bus.app_switch && bus.dark && !bus.movement) begin m_state = 3; m_age = 0; end
                else if (tgt != m_level) begin m_state = 1; m_age = 0; end
            end
            default: begin
                if (req != 0) begin m_state = (tgt != m_level) ? 1 : 2; m_age = 0; end
                else if (!bus.dark) begin m_state = 1; m_age = 0; end
                else if (m_age == HOLD_CYCLES - 1) begin m_state = 1; m_age = 0; end
                else m_age++;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("state", 32'(bus.state), 32'(m_state));
        check("level", 32'(bus.level), 32'(m_level));
        check("light_control", 32'(bus.light_control), 32'(m_lc));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_in(input logic app, input logic drk, input logic mov, input logic [7:0] ri);
        bus.app_switch     = app;
        bus.dark           = drk;
        bus.movement       = mov;
        bus.room_intensity = ri;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_level", 32'(bus.level), 32'd0);
        check("reset_lc", 32'(bus.light_control), 32'd0);
        rst = 1'b0;

        // Manual on/off at 128
        set_in(1'b1, 1'b0, 1'b0, 8'd128);
        tick();
        check("t1_enter_ramp", 32'(bus.state), 32'd1);
        run(256);
        check("t1_level_128", 32'(bus.level), 32'd128);
        tick();
        check("t1_on", 32'(bus.state), 32'd2);
        hi_cnt = 0;
        repeat (256) begin
            tick();
            hi_cnt += int'(bus.light_control);
        end
        check("t1_pwm_duty", 32'(hi_cnt), 32'd128);
        set_in(1'b0, 1'b0, 1'b0, 8'd128);
        tick();
        check("t1_ramp_down", 32'(bus.state), 32'd1);
        run(256);
        check("t1_level_0", 32'(bus.level), 32'd0);
        tick();
        check("t1_off", 32'(bus.state), 32'd0);

        // Daylight: movement alone must not light the room
        set_in(1'b0, 1'b0, 1'b1, 8'd255);
        run(20);
        check("t3_off", 32'(bus.state), 32'd0);
        check("t3_level", 32'(bus.level), 32'd0);
        check("t3_lc", 32'(bus.light_control), 32'd0);

        // Auto in darkness, hold retrigger, timeout ramp-down
        set_in(1'b0, 1'b1, 1'b1, 8'd200);
        tick();
        run(400);
        check("t2_level_200", 32'(bus.level), 32'd200);
        tick();
        check("t2_on", 32'(bus.state), 32'd2);
        set_in(1'b0, 1'b1, 1'b0, 8'd200);
        tick();
        check("t2_hold", 32'(bus.state), 32'd3);
        run(5);
        set_in(1'b0, 1'b1, 1'b1, 8'd200);
        tick();
        check("t4_retrigger_on", 32'(bus.state), 32'd2);
        check("t4_level_kept", 32'(bus.level), 32'd200);
        set_in(1'b0, 1'b1, 1'b0, 8'd200);
        tick();
        run(9);
        check("t4_hold_last", 32'(bus.state), 32'd3);
        tick();
        check("t2_timeout_ramp", 32'(bus.state), 32'd1);
        run(400);
        check("t2_level_0", 32'(bus.level), 32'd0);
        tick();
        check("t2_off", 32'(bus.state), 32'd0);

        // Intensity change while ON, then dark lost in HOLD
        set_in(1'b0, 1'b1, 1'b1, 8'd200);
        run(402);
        check("t5_on", 32'(bus.state), 32'd2);
        set_in(1'b0, 1'b1, 1'b1, 8'd64);
        tick();
        check("t5_ramp", 32'(bus.state), 32'd1);
        run(272);
        check("t5_level_64", 32'(bus.level), 32'd64);
        tick();
        check("t5_on64", 32'(bus.state), 32'd2);
        set_in(1'b0, 1'b1, 1'b0, 8'd64);
        tick();
        run(3);
        check("t5_hold", 32'(bus.state), 32'd3);
        set_in(1'b0, 1'b0, 1'b0, 8'd64);
        tick();
        check("t5_dark_lost", 32'(bus.state), 32'd1);
        run(128);
        tick();
        check("t5_off", 32'(bus.state), 32'd0);

        // Asynchronous reset mid-ramp
        set_in(1'b1, 1'b0, 1'b0, 8'd200);
        tick();
        run(154);
        check("t6_level_77", 32'(bus.level), 32'd77);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_level", 32'(bus.level), 32'd0);
        check("t6_rst_state", 32'(bus.state), 32'd0);
        check("t6_rst_lc", 32'(bus.light_control), 32'd0);
        m_state = 0; m_level = 0; m_age = 0; m_t = 0; m_lc = 0;
        run(2);
        rst = 1'b0;
        tick();
        check("t6_restart_ramp", 32'(bus.state), 32'd1);
        run(2);
        check("t6_level_1", 32'(bus.level), 32'd1);

        // Randomized segments
        for (int s = 0; s < 40; s++) begin
            logic [7:0] ri;
            ri = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ri = 8'd255;
            if ($urandom_range(0, 7) == 0) ri = 8'd0;
            set_in(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ri);
            run(int'($urandom_range(1, 300)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
